// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encodings and
// the per-cycle stage-control vector with its RUN defaults.
package pipeline_hazard_ctrl_pkg;

    localparam int PHC_ST_BIT = 2;
    localparam int REG_W      = 5;

    typedef enum logic [PHC_ST_BIT-1:0] {
        PHC_ST_RUN    = 2'd0,
        PHC_ST_DRAIN  = 2'd1,
        PHC_ST_HALTED = 2'd2,
        PHC_ST_RESUME = 2'd3
    } phc_state_e;

    // clr fields are active-low and override the matching en field in the datapath
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_dm_en;
        logic dm_wb_en;
        logic if_id_clr;
        logic id_ex_clr;
        logic ex_dm_clr;
        logic dm_wb_clr;
        logic halted;
    } phc_ctrl_t;

    localparam phc_ctrl_t PHC_RUN_DEFAULT = '{
        pc_en:     1'b1,
        if_id_en:  1'b1,
        id_ex_en:  1'b1,
        ex_dm_en:  1'b1,
        dm_wb_en:  1'b1,
        if_id_clr: 1'b1,
        id_ex_clr: 1'b1,
        ex_dm_clr: 1'b1,
        dm_wb_clr: 1'b1,
        halted:    1'b0
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-info / stage-control bundle between the datapath (master) and the
// hazard controller (slave). CNT_WIDTH sizes the performance counters.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0]     id_req_a;
    logic [REG_W-1:0]     id_req_b;
    logic                 id_use_a;
    logic                 id_use_b;
    logic [REG_W-1:0]     ex_req_w;
    logic                 ex_w_en;
    logic                 ex_is_load;
    logic                 ex_branch_taken;
    logic                 ex_halt;
    logic                 wb_halt;
    logic                 resume;

    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_dm_en;
    logic                 dm_wb_en;
    logic                 if_id_clr;
    logic                 id_ex_clr;
    logic                 ex_dm_clr;
    logic                 dm_wb_clr;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_cycles;

    modport master (
        output id_req_a, id_req_b, id_use_a, id_use_b, ex_req_w, ex_w_en,
               ex_is_load, ex_branch_taken, ex_halt, wb_halt, resume,
        input  pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
               if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr, halted,
               stall_cycles, flush_cycles
    );

    modport slave (
        input  id_req_a, id_req_b, id_use_a, id_use_b, ex_req_w, ex_w_en,
               ex_is_load, ex_branch_taken, ex_halt, wb_halt, resume,
        output pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
               if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr, halted,
               stall_cycles, flush_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Pure compare logic: flags an ID instruction reading a register that the
// load currently in EX has not yet fetched from data memory.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_id_req_a,
    input  logic [REG_W-1:0] i_id_req_b,
    input  logic             i_id_use_a,
    input  logic             i_id_use_b,
    input  logic [REG_W-1:0] i_ex_req_w,
    input  logic             i_ex_w_en,
    input  logic             i_ex_is_load,
    output logic             o_load_use
);

    logic w_hit_a;
    logic w_hit_b;

    assign w_hit_a = i_id_use_a && (i_id_req_a == i_ex_req_w);
    assign w_hit_b = i_id_use_b && (i_id_req_b == i_ex_req_w);

    // $0 is hardwired, so a load targeting it never creates a real dependency
    assign o_load_use = i_ex_w_en && i_ex_is_load && (i_ex_req_w != '0)
                        && (w_hit_a || w_hit_b);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enable/clear sequencer for IF/ID, ID/EX, EX/DM, DM/WB and the PC.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    phc_state_e r_state;
    phc_state_e w_next;
    phc_ctrl_t  w_ctrl;
    logic       w_load_use;

    load_use_detect u_load_use_detect (
        .i_id_req_a   (bus.id_req_a),
        .i_id_req_b   (bus.id_req_b),
        .i_id_use_a   (bus.id_use_a),
        .i_id_use_b   (bus.id_use_b),
        .i_ex_req_w   (bus.ex_req_w),
        .i_ex_w_en    (bus.ex_w_en),
        .i_ex_is_load (bus.ex_is_load),
        .o_load_use   (w_load_use)
    );

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PHC_ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        w_next = r_state;
        w_ctrl = PHC_RUN_DEFAULT;
        unique case (r_state)
            PHC_ST_RUN: begin
                if (bus.ex_halt) begin
                    w_ctrl.pc_en     = 1'b0;
                    w_ctrl.if_id_en  = 1'b0;
                    w_ctrl.id_ex_clr = 1'b0;
                end else if (bus.ex_branch_taken) begin
                    w_ctrl.if_id_clr = 1'b0;
                    w_ctrl.id_ex_clr = 1'b0;
                end else if (w_load_use) begin
                    w_ctrl.pc_en     = 1'b0;
                    w_ctrl.if_id_en  = 1'b0;
                    w_ctrl.id_ex_clr = 1'b0;
                end
                // A halt flag already at WB means DRAIN was skipped; stop now
                if (bus.wb_halt) begin
                    w_next = PHC_ST_HALTED;
                end else if (bus.ex_halt) begin
                    w_next = PHC_ST_DRAIN;
                end
            end
            PHC_ST_DRAIN: begin
                w_ctrl.pc_en     = 1'b0;
                w_ctrl.if_id_en  = 1'b0;
                w_ctrl.id_ex_clr = 1'b0;
                if (bus.wb_halt) begin
                    w_next = PHC_ST_HALTED;
                end
            end
            PHC_ST_HALTED: begin
                w_ctrl.pc_en    = 1'b0;
                w_ctrl.if_id_en = 1'b0;
                w_ctrl.id_ex_en = 1'b0;
                w_ctrl.ex_dm_en = 1'b0;
                w_ctrl.dm_wb_en = 1'b0;
                w_ctrl.halted   = 1'b1;
                if (bus.resume) begin
                    w_next = PHC_ST_RESUME;
                end
            end
            PHC_ST_RESUME: begin
                // Flush the halted syscall out of the back end; front end stays frozen
                w_ctrl.pc_en     = 1'b0;
                w_ctrl.if_id_en  = 1'b0;
                w_ctrl.id_ex_clr = 1'b0;
                w_ctrl.ex_dm_clr = 1'b0;
                w_ctrl.dm_wb_clr = 1'b0;
                w_next           = PHC_ST_RUN;
            end
            default: w_next = PHC_ST_RUN;
        endcase
    end

    assign bus.pc_en     = w_ctrl.pc_en;
    assign bus.if_id_en  = w_ctrl.if_id_en;
    assign bus.id_ex_en  = w_ctrl.id_ex_en;
    assign bus.ex_dm_en  = w_ctrl.ex_dm_en;
    assign bus.dm_wb_en  = w_ctrl.dm_wb_en;
    assign bus.if_id_clr = w_ctrl.if_id_clr;
    assign bus.id_ex_clr = w_ctrl.id_ex_clr;
    assign bus.ex_dm_clr = w_ctrl.ex_dm_clr;
    assign bus.dm_wb_clr = w_ctrl.dm_wb_clr;
    assign bus.halted    = w_ctrl.halted;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam int CW = $bits(bus.stall_cycles);

    logic [CW-1:0] r_stall_cycles;
    logic [CW-1:0] r_flush_cycles;
    logic          w_stall_inc;
    logic          w_flush_inc;

    assign w_stall_inc = (r_state == PHC_ST_RUN) && !w_ctrl.pc_en;
    assign w_flush_inc = (r_state == PHC_ST_RUN) && !bus.ex_halt && bus.ex_branch_taken;

    // Saturate at all-ones rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_flush_inc && (r_flush_cycles != '1)) begin
                r_flush_cycles <= r_flush_cycles + 1'b1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_cycles = r_flush_cycles;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard/halt/reset
// scenarios plus randomized RUN-mode hazards against a rule-level model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_WIDTH(32)) bus ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: pipeline mode plus expected counter totals
    typedef enum int { M_RUN, M_DRAIN, M_HALTED, M_RESUME } mode_e;
    mode_e       m_mode;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_load_use();
        logic [4:0] src [2];
        bit         use_src [2];
        src[0] = bus.id_req_a; use_src[0] = bus.id_use_a;
        src[1] = bus.id_req_b; use_src[1] = bus.id_use_b;
        if (!(bus.ex_w_en && bus.ex_is_load) || bus.ex_req_w == 5'd0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (use_src[i] && src[i] == bus.ex_req_w) return 1'b1;
        return 1'b0;
    endfunction

    // {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr, halted}
    function automatic logic [31:0] model_vec();
        logic [9:0] v;
        v = 10'b11111_1111_0;
        case (m_mode)
            M_RUN: begin
                if (bus.ex_halt || (!bus.ex_branch_taken && model_load_use()))
                    v = 10'b00111_1011_0;
                else if (bus.ex_branch_taken)
                    v = 10'b11111_0011_0;
            end
            M_DRAIN:  v = 10'b00111_1011_0;
            M_HALTED: v = 10'b00000_1111_1;
            M_RESUME: v = 10'b00111_1000_0;
            default:  v = 10'b11111_1111_0;
        endcase
        return {22'd0, v};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {22'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_dm_en, bus.dm_wb_en,
                bus.if_id_clr, bus.id_ex_clr, bus.ex_dm_clr, bus.dm_wb_clr, bus.halted};
    endfunction

    function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef PIPE_CTRL_PERF_CNT_EN
        return c;
`else
        return (c & 32'd0);
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".ctrl"},  dut_vec(),          model_vec());
        check({tag, ".stall"}, bus.stall_cycles,   exp_cnt(m_stall));
        check({tag, ".flush"}, bus.flush_cycles,   exp_cnt(m_flush));
    endtask

    // Check mid-cycle, then advance the model across the rising edge
    task automatic step(input string tag);
        mode_e nxt;
        @(negedge clk);
        check_all(tag);
        nxt = m_mode;
        case (m_mode)
            M_RUN: begin
                if (bus.ex_halt || (!bus.ex_branch_taken && model_load_use()))
                    if (m_stall != 32'hFFFF_FFFF) m_stall++;
                if (!bus.ex_halt && bus.ex_branch_taken)
                    if (m_flush != 32'hFFFF_FFFF) m_flush++;
                if (bus.wb_halt)      nxt = M_HALTED;
                else if (bus.ex_halt) nxt = M_DRAIN;
            end
            M_DRAIN:  if (bus.wb_halt) nxt = M_HALTED;
            M_HALTED: if (bus.resume)  nxt = M_RESUME;
            M_RESUME: nxt = M_RUN;
            default:  nxt = M_RUN;
        endcase
        @(posedge clk);
        if (rst_n) m_mode = nxt;
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_req_a = '0; bus.id_req_b = '0; bus.id_use_a = 1'b0; bus.id_use_b = 1'b0;
        bus.ex_req_w = '0; bus.ex_w_en = 1'b0; bus.ex_is_load = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.ex_halt = 1'b0; bus.wb_halt = 1'b0; bus.resume = 1'b0;
    endtask

    task automatic model_reset();
        m_mode  = M_RUN;
        m_stall = '0;
        m_flush = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        step("reset_hold");
        step("reset_hold2");
        rst_n = 1'b1;
        step("after_reset");

        // lw $8 in EX, ID reads $8 -> one bubble
        bus.ex_req_w = 5'd8; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
        bus.id_req_a = 5'd8; bus.id_use_a = 1'b1;
        step("load_use_r8");
        idle_inputs();
        step("post_load_use");
        check("stall_after_lu", bus.stall_cycles, exp_cnt(32'd1));

        // lw $0 with ID reading $0 -> no stall
        bus.ex_req_w = 5'd0; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
        bus.id_req_a = 5'd0; bus.id_use_a = 1'b1; bus.id_req_b = 5'd0; bus.id_use_b = 1'b1;
        step("load_use_r0");
        check("r0_pc_en", {31'd0, bus.pc_en}, 32'd1);

        // Source B match only, source not used -> no stall
        idle_inputs();
        bus.ex_req_w = 5'd3; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
        bus.id_req_b = 5'd3; bus.id_use_b = 1'b0;
        step("unused_src");
        bus.id_use_b = 1'b1;
        step("load_use_b");

        // Taken branch pulse
        idle_inputs();
        bus.ex_branch_taken = 1'b1;
        step("branch");
        idle_inputs();
        step("post_branch");
        check("flush_after_br", bus.flush_cycles, exp_cnt(32'd1));

        // Halt wins over a simultaneous load-use
        bus.ex_req_w = 5'd9; bus.ex_w_en = 1'b1; bus.ex_is_load = 1'b1;
        bus.id_req_a = 5'd9; bus.id_use_a = 1'b1; bus.ex_halt = 1'b1;
        step("halt_N");
        idle_inputs();
        step("drain_N1");
        bus.wb_halt = 1'b1;
        step("drain_N2_wbhalt");
        check("halted_N3", {31'd0, bus.halted}, 32'd1);
        for (int i = 0; i < 10; i++) step("halted_hold");

        // Resume: one cycle of back-end clear, then RUN
        bus.resume = 1'b1;
        step("resume_edge");
        bus.resume = 1'b0;
        step("resume_cycle");
        bus.wb_halt = 1'b0;
        step("run_after_resume");
        check("halted_cleared", {31'd0, bus.halted}, 32'd0);

        // Randomized RUN-mode hazards, resume must be ignored here
        for (int n = 0; n < 300; n++) begin
            bus.id_req_a        = 5'($urandom_range(0, 3));
            bus.id_req_b        = 5'($urandom_range(0, 3));
            bus.id_use_a        = 1'($urandom_range(0, 1));
            bus.id_use_b        = 1'($urandom_range(0, 1));
            bus.ex_req_w        = 5'($urandom_range(0, 3));
            bus.ex_w_en         = 1'($urandom_range(0, 1));
            bus.ex_is_load      = 1'($urandom_range(0, 1));
            bus.ex_branch_taken = ($urandom_range(0, 3) == 0);
            bus.resume          = 1'($urandom_range(0, 1));
            step("random");
        end
        idle_inputs();
        step("random_end");

        // Defensive: wb_halt seen in RUN goes straight to HALTED
        bus.wb_halt = 1'b1;
        step("run_wbhalt");
        step("halted_direct");
        bus.resume = 1'b1;
        step("resume2_edge");
        idle_inputs();
        step("resume2_cycle");
        step("run2");

        // Reset asserted mid-DRAIN
        bus.ex_halt = 1'b1;
        step("halt_before_rst");
        bus.ex_halt = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        step("rst_held");
        rst_n = 1'b1;
        step("rst_release");
        step("rst_release2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencer for the four pipeline registers (IF/ID, ID/EX, EX/DM, DM/WB) and the PC. It generates every stage's advance enable and active-low clear from EX/WB hazard information. It handles load-use stalls, taken-branch flushes, and the syscall halt drain/resume sequence. It sits beside the datapath in the core top; its outputs drive the existing `en`/`clr` ports directly.

## Interface
- CNT_WIDTH, 32, width of the performance counters.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_req_a / id_req_b  in  5  source register numbers of the instruction in ID.
- id_use_a / id_use_b  in  1  ID instruction actually reads that source.
- ex_req_w  in  5  destination register of the instruction in EX.
- ex_w_en  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction's write-back data comes from data memory.
- ex_branch_taken  in  1  EX resolved a taken branch/jump; PC mux loads the target this cycle.
- ex_halt  in  1  EX holds a halting syscall.
- wb_halt  in  1  halt flag at the DM/WB output.
- resume  in  1  restart request, honoured only in HALTED.
- pc_en  out  1  PC register load enable.
- if_id_en, id_ex_en, ex_dm_en, dm_wb_en  out  1 each  stage advance; 0 = hold.
- if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr  out  1 each  active-low stage clear; takes priority over en.
- halted  out  1  core is in HALTED.
- stall_cycles, flush_cycles  out  CNT_WIDTH each  performance counters.

## Operation
- load_use = ex_w_en & ex_is_load & (ex_req_w != 0) & ((id_use_a & id_req_a == ex_req_w) | (id_use_b & id_req_b == ex_req_w)).
- FSM states: RUN, DRAIN, HALTED, RESUME. Reset state is RUN.
- Default output vector: all en = 1, all clr = 1, halted = 0.
- **RUN**, evaluated in priority order:
  - ex_halt: pc_en = 0, if_id_en = 0, id_ex_clr = 0. Next state DRAIN.
  - else ex_branch_taken: if_id_clr = 0, id_ex_clr = 0, pc_en = 1.
  - else load_use: pc_en = 0, if_id_en = 0, id_ex_clr = 0 (bubble inserted).
  - wb_halt in RUN (defensive case): next state HALTED.
- **DRAIN:**
  - Outputs: pc_en = 0, if_id_en = 0, id_ex_clr = 0; EX/DM and DM/WB advance.
  - wb_halt = 1 moves to HALTED.
  - IF/ID keeps halt+4 and PC keeps halt+8, so the front end stays coherent.
- **HALTED:**
  - Outputs: all en = 0, all clr = 1, halted = 1.
  - resume = 1 moves to RESUME.
- **RESUME (one cycle):**
  - Outputs: ex_dm_clr = 0, dm_wb_clr = 0 (drops the halt flag); id_ex_clr = 0; pc_en = 0, if_id_en = 0.
  - Next state RUN, with fetch continuing from the frozen PC.
- resume outside HALTED is ignored.
- Counters (saturating at all-ones):
  - stall_cycles +1 on every cycle with pc_en = 0 in RUN.
  - flush_cycles +1 on every cycle with if_id_clr = 0 caused by a branch.

## Timing
- All enable/clear outputs are combinational from state plus current inputs. They act on the same clock edge as the hazard that caused them (zero-cycle latency).
- FSM state and counters are registered.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- ex_halt to halted = 1: 3 cycles (EX→DM→WB, then HALTED is registered).
- resume to first new instruction in EX: RESUME cycle, then RUN; halt+4 enters EX 2 cycles after the resume edge.
- Reset values: state = RUN, halted = 0, stall_cycles = 0, flush_cycles = 0; enables and clears take the RUN defaults.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately.
- Simultaneous ex_halt and load_use: halt wins. A load_use against register 0 never stalls.

## Configuration
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined: stall_cycles and flush_cycles count as described.
- Undefined: no counter flops; both outputs tied to 0 and the ports remain present.

## Structure
- The following are added to Core.vh:
  - state encodings `PHC_ST_RUN`, `PHC_ST_DRAIN`, `PHC_ST_HALTED`, `PHC_ST_RESUME`;
  - width macro `PHC_ST_BIT` = 2.
- One sub-module: load_use_detect, which is pure compare logic producing load_use.

## Test plan
- ID reads $8, EX is lw $8 → one cycle with pc_en = 0, if_id_en = 0, id_ex_clr = 0; stall_cycles goes 0→1.
- EX is lw $0, ID reads $0 → no stall, all en = 1.
- ex_branch_taken pulse → if_id_clr = 0 and id_ex_clr = 0 for that cycle, pc_en = 1; flush_cycles = 1.
- ex_halt at cycle N, wb_halt at N+2 → halted = 1 from N+3; all en = 0 held for 10 cycles.
- In HALTED, resume pulse → exactly one cycle of dm_wb_clr = 0 and ex_dm_clr = 0, then RUN defaults; halted = 0.
- rst_n low during DRAIN → halted = 0, counters = 0, RUN outputs on release.
